// File: rtl/accel_servo_cmd.sv
// Per-axis servo command conditioning: boxcar average, clamp, linear map to pulse width,
// and per-frame slew limiting of the commanded width.
module accel_servo_cmd #(
    parameter int AVG_LOG2     = 3,
    parameter int IN_MIN       = -256,
    parameter int IN_SPAN_LOG2 = 9,
    parameter int PW_MIN       = 50000,
    parameter int PW_MAX       = 100000,
    parameter int STEP_MAX     = 500,
    parameter int FRAME        = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               sample_valid,
    input  logic signed [15:0] sample,
    output logic        [16:0] pw_out,
    output logic               pw_valid,
    output logic               frame_tick
);

    localparam int ACC_W  = 16 + AVG_LOG2;
    localparam int PROD_W = IN_SPAN_LOG2 + 17;
    localparam int FC_W   = (FRAME > 1) ? $clog2(FRAME) : 1;

    localparam logic signed [15:0]   L_IN_MIN    = 16'(IN_MIN);
    localparam logic signed [15:0]   L_IN_MAX    = 16'(IN_MIN + (1 << IN_SPAN_LOG2) - 1);
    localparam logic        [16:0]   L_PW_MIN    = 17'(PW_MIN);
    localparam logic        [16:0]   L_PW_RANGE  = 17'(PW_MAX - PW_MIN);
    localparam logic        [16:0]   L_PW_CENTER = 17'((PW_MIN + PW_MAX) / 2);
    localparam logic signed [17:0]   L_STEP      = 18'(STEP_MAX);
    localparam logic        [16:0]   L_STEP_U    = 17'(STEP_MAX);
    localparam logic [FC_W-1:0]      L_FC_LAST   = FC_W'(FRAME - 1);
    localparam logic [AVG_LOG2-1:0]  L_CNT_LAST  = {AVG_LOG2{1'b1}};

    logic signed [ACC_W-1:0]        r_acc;
    logic        [AVG_LOG2-1:0]     r_cnt;
    logic signed [15:0]             r_avg;
    logic                           r_avg_vld;
    logic        [IN_SPAN_LOG2-1:0] r_off;
    logic                           r_off_vld;
    logic        [16:0]             r_target;
    logic        [FC_W-1:0]         r_fcnt;
    logic        [16:0]             r_pw;
    logic                           r_pw_valid;
    logic                           r_frame_tick;

    logic signed [ACC_W-1:0]        w_sum;
    logic signed [15:0]             w_clamped;
    logic        [IN_SPAN_LOG2-1:0] w_off;
    logic        [PROD_W-1:0]       w_prod;
    logic        [16:0]             w_target_new;
    logic signed [17:0]             w_diff;
    logic        [16:0]             w_pw_next;

    // Dropping the low AVG_LOG2 bits of the signed sum is the arithmetic shift (floor).
    assign w_sum = r_acc + {{AVG_LOG2{sample[15]}}, sample};

    // Stage 1: accumulate accepted samples and register the batch average.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_avg     <= '0;
            r_avg_vld <= 1'b0;
        end else if (!en) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_avg_vld <= 1'b0;
        end else if (sample_valid) begin
            if (r_cnt == L_CNT_LAST) begin
                r_acc     <= '0;
                r_cnt     <= '0;
                r_avg     <= w_sum[ACC_W-1:AVG_LOG2];
                r_avg_vld <= 1'b1;
            end else begin
                r_acc     <= w_sum;
                r_cnt     <= r_cnt + 1'b1;
                r_avg_vld <= 1'b0;
            end
        end else begin
            r_avg_vld <= 1'b0;
        end
    end

    // Limit the average to the accepted input window.
    always_comb begin
        w_clamped = r_avg;
        if (r_avg < L_IN_MIN) begin
            w_clamped = L_IN_MIN;
        end else if (r_avg > L_IN_MAX) begin
            w_clamped = L_IN_MAX;
        end else begin
            w_clamped = r_avg;
        end
    end

    assign w_off = IN_SPAN_LOG2'(w_clamped - L_IN_MIN);

    // Stage 2: register the offset from the bottom of the input window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_off     <= '0;
            r_off_vld <= 1'b0;
        end else begin
            r_off     <= w_off;
            r_off_vld <= r_avg_vld & en;
        end
    end

    assign w_prod       = PROD_W'(r_off) * PROD_W'(L_PW_RANGE);
    assign w_target_new = 17'(w_prod >> IN_SPAN_LOG2) + L_PW_MIN;

    // Stage 3: target width; a disabled axis is parked at center.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= L_PW_CENTER;
        end else if (!en) begin
            r_target <= L_PW_CENTER;
        end else if (r_off_vld) begin
            r_target <= w_target_new;
        end else begin
            r_target <= r_target;
        end
    end

    // Free-running frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt <= '0;
        end else if (r_fcnt == L_FC_LAST) begin
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    assign w_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_pw});

    // Move at most STEP_MAX toward the target per frame.
    always_comb begin
        w_pw_next = r_target;
        if (w_diff > L_STEP) begin
            w_pw_next = r_pw + L_STEP_U;
        end else if (w_diff < -L_STEP) begin
            w_pw_next = r_pw - L_STEP_U;
        end else begin
            w_pw_next = r_target;
        end
    end

    // Frame-boundary update of the commanded width and its strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pw         <= L_PW_CENTER;
            r_pw_valid   <= 1'b0;
            r_frame_tick <= 1'b0;
        end else if (r_fcnt == L_FC_LAST) begin
            r_pw         <= w_pw_next;
            r_pw_valid   <= 1'b1;
            r_frame_tick <= 1'b1;
        end else begin
            r_pw_valid   <= 1'b0;
            r_frame_tick <= 1'b0;
        end
    end

    assign pw_out     = r_pw;
    assign pw_valid   = r_pw_valid;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_accel_servo_cmd.sv
// Directed + randomized bench for accel_servo_cmd with a frame-level behavioural model.
module tb_accel_servo_cmd;

    localparam int FRAME    = 100;
    localparam int NAVG     = 8;
    localparam int IN_MIN   = -256;
    localparam int IN_MAX   = 255;
    localparam int PW_MIN   = 50000;
    localparam int PW_MAX   = 100000;
    localparam int CENTER   = 75000;
    localparam int STEP     = 500;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               sample_valid;
    logic signed [15:0] sample;
    logic        [16:0] pw_out;
    logic               pw_valid;
    logic               frame_tick;

    int cyc = 0;
    int last_tick = 0;
    int n_pass = 0;
    int n_checks = 0;
    int m_pw, m_tgt, m_sum, m_cnt;

    accel_servo_cmd #(.FRAME(FRAME)) dut (
        .clk(clk), .rst(rst), .en(en), .sample_valid(sample_valid), .sample(sample),
        .pw_out(pw_out), .pw_valid(pw_valid), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Average rounds toward minus infinity, then clamp and scale to the pulse range.
    function automatic int model_target(input int sum);
        int avg;
        longint off;
        if (sum >= 0) avg = sum / NAVG;
        else avg = -((-sum + NAVG - 1) / NAVG);
        if (avg < IN_MIN) avg = IN_MIN;
        if (avg > IN_MAX) avg = IN_MAX;
        off = longint'(avg - IN_MIN);
        return PW_MIN + int'((off * (PW_MAX - PW_MIN)) / 512);
    endfunction

    task automatic model_reset();
        m_pw = CENTER; m_tgt = CENTER; m_sum = 0; m_cnt = 0;
    endtask

    task automatic send(input int v);
        sample = 16'(v);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        if (en) begin
            m_sum += v;
            m_cnt++;
            if (m_cnt == NAVG) begin
                m_tgt = model_target(m_sum);
                m_sum = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic set_en(input logic v);
        en = v;
        if (!v) begin
            m_sum = 0; m_cnt = 0; m_tgt = CENTER;
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        int d;
        @(negedge clk);
        while (frame_tick !== 1'b1 && n < FRAME + 5) begin
            @(negedge clk);
            n++;
        end
        check("tick_seen", frame_tick, 1);
        if (frame_tick === 1'b1) begin
            d = m_tgt - m_pw;
            if (d > STEP) m_pw += STEP;
            else if (d < -STEP) m_pw -= STEP;
            else m_pw = m_tgt;
            check("tick_period", cyc - last_tick, FRAME);
            check("pw_out", pw_out, m_pw);
            check("pw_valid_hi", pw_valid, 1);
            last_tick = cyc;
            @(negedge clk);
            check("tick_lo", frame_tick, 0);
            check("pw_valid_lo", pw_valid, 0);
        end
    endtask

    task automatic run(input int frames);
        for (int i = 0; i < frames; i++) wait_tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_pw", pw_out, CENTER);
        check("rst_valid", pw_valid, 0);
        check("rst_tick", frame_tick, 0);
        rst = 1'b0;
        last_tick = cyc;
        set_en(1'b1);

        repeat (8) send(0);
        run(2);
        check("zero_pw", pw_out, CENTER);

        repeat (8) send(255);
        run(1);
        check("ramp_first", pw_out, 75500);
        run(50);
        check("full_scale", pw_out, 99902);

        repeat (8) send(1000);
        run(1);
        check("clamp_hi", pw_out, 99902);
        repeat (8) send(-1000);
        run(100);
        check("clamp_lo", pw_out, 50000);

        repeat (8) send(-1);
        run(50);
        check("minus_one", pw_out, 74902);
        repeat (4) begin send(-8); send(8); end
        run(1);
        check("alternate", pw_out, CENTER);

        // Reset in the middle of an upward ramp.
        repeat (8) send(255);
        run(5);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_pw", pw_out, CENTER);
        check("midrst_valid", pw_valid, 0);
        check("midrst_tick", frame_tick, 0);
        rst = 1'b0;
        last_tick = cyc;
        model_reset();
        run(1);
        check("post_rst_pw", pw_out, CENTER);

        // Partial batch discarded across an enable drop.
        repeat (5) send(255);
        set_en(1'b0);
        repeat (10) @(negedge clk);
        set_en(1'b1);
        repeat (8) send(0);
        run(3);
        check("partial_drop", pw_out, CENTER);

        // Disabled axis ramps back to center.
        repeat (8) send(255);
        run(51);
        check("en_full", pw_out, 99902);
        set_en(1'b0);
        run(51);
        check("en_off_center", pw_out, CENTER);
        set_en(1'b1);

        // Randomized batches with occasional enable drops.
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 8; k++) send(int'($urandom_range(3000)) - 1500);
            if ($urandom_range(1) == 1) begin
                for (int k = 0; k < 3; k++) send(int'($urandom_range(600)) - 300);
                set_en(1'b0);
                repeat (4) @(negedge clk);
                set_en(1'b1);
            end
            run(3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
